// File: rtl/eth_crc32.sv
// -----------------------------------------------------------------------------
// eth_crc32
//
// Ethernet FCS (CRC-32) accumulator for MAC transmit and receive paths.
// Folds a WIDTH-bit data fragment into a 32-bit reflected CRC register on
// every enabled clock. The polynomial is 0x04C11DB7, processed in reflected
// form (0xEDB88320), LSB-first. The init value is 0xFFFFFFFF.
//
// Transmit: after the last payload fragment the FCS is ~crc, sent LSB-first.
// Receive : after the FCS bytes have also been fed, a good frame leaves the
//           register at 0xDEBB20E3.
//
// Ports
//   clk    in   1      single clock, rising edge
//   rst_n  in   1      asynchronous active-low reset, loads init value
//   clr    in   1      synchronous clear to init value, wins over en
//   en     in   1      fold din into the CRC on this edge
//   din    in   WIDTH  data fragment, din[0] is the earliest bit on the wire
//   crc    out  32     CRC register, straight from the flop, not inverted
//
// There is no handshake: en is a plain qualifier with no backpressure, one
// fragment may be accepted on every clock, and idle cycles leave the
// register untouched.
// -----------------------------------------------------------------------------
module eth_crc32 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [31:0]      crc
);

    localparam logic [31:0] CRC_POLY = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;

    // Only bit-serial, dibit, nibble and byte datapaths are supported.
    generate
        if (!(WIDTH == 1 || WIDTH == 2 || WIDTH == 4 || WIDTH == 8)) begin : g_bad_width
            $error("eth_crc32: WIDTH must be 1, 2, 4 or 8");
        end
    endgenerate

    logic [31:0] crc_q;
    logic [31:0] crc_d;

    // WIDTH unrolled single-bit LFSR steps, earliest wire bit (din[0]) first.
    // Feeding a byte as four dibits therefore gives the same result as
    // feeding it in one byte-wide step.
    function automatic logic [31:0] crc_fold(input logic [31:0]      c,
                                             input logic [WIDTH-1:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < WIDTH; i++) begin
            r = (r >> 1) ^ (((r[0] ^ d[i]) == 1'b1) ? CRC_POLY : 32'h0);
        end
        return r;
    endfunction

    // Clear outranks enable, so din is discarded when both are high.
    // din only reaches the register through the en branch, so an unknown
    // din while idle cannot corrupt the accumulated value.
    always_comb begin
        crc_d = crc_q;
        if (clr) begin
            crc_d = CRC_INIT;
        end else if (en) begin
            crc_d = crc_fold(crc_q, din);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_q <= CRC_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

// File: tb/tb_eth_crc32.sv
// -----------------------------------------------------------------------------
// tb_eth_crc32
//
// Runs a byte-wide and a dibit-wide eth_crc32 side by side. Every clock the
// bench drives both instances, advances a bit-serial reference model for
// each, pushes the model value into that instance's expected queue, and one
// edge later pops and compares against the register. Known check values
// (0x340BC6D9, 0x2DFD1072, 0xDEBB20E3) are also compared as constants.
// -----------------------------------------------------------------------------
module tb_eth_crc32;

    localparam logic [31:0] POLY = 32'hEDB88320;
    localparam logic [31:0] INIT = 32'hFFFF_FFFF;
    localparam logic [31:0] RESIDUE = 32'hDEBB20E3;
    localparam logic [31:0] CHECK_REG = 32'h340BC6D9;
    localparam int FRAME_LEN = 100;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic        clr = 1'b0;
    logic        en8 = 1'b0;
    logic [7:0]  din8 = 8'h00;
    logic [31:0] crc8;
    logic        en2 = 1'b0;
    logic [1:0]  din2 = 2'b00;
    logic [31:0] crc2;

    eth_crc32 #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .en    (en8),
        .din   (din8),
        .crc   (crc8)
    );

    eth_crc32 #(.WIDTH(2)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .en    (en2),
        .din   (din2),
        .crc   (crc2)
    );

    // ---------------- scoreboard ----------------
    logic [31:0] exp_q8[$];
    logic [31:0] exp_q2[$];
    logic [31:0] model8;
    logic [31:0] model2;
    int checks = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s obs=%08h exp=%08h", tag, obs, exp);
        end
    endtask

    // Bit-serial reference: n steps over d[0..n-1], LSB-first.
    function automatic logic [31:0] ref_crc(input logic [31:0] c, input logic [7:0] d, input int n);
        logic [31:0] r;
        logic        fb;
        r = c;
        for (int i = 0; i < n; i++) begin
            fb = r[0] ^ d[i];
            r  = (r >> 1) ^ (fb ? POLY : 32'h0);
        end
        return r;
    endfunction

    // ---------------- driver ----------------
    // One clock: drive inputs at the falling edge, update models, push
    // expectations, then compare one falling edge later. Idle din is random.
    task automatic tick(input logic e8, input logic [7:0] d8,
                        input logic e2, input logic [1:0] d2, input logic c);
        logic [31:0] e8_v;
        logic [31:0] e2_v;
        clr  = c;
        en8  = e8;
        din8 = e8 ? d8 : 8'($urandom);
        en2  = e2;
        din2 = e2 ? d2 : 2'($urandom);
        if (c) begin
            model8 = INIT;
            model2 = INIT;
        end else begin
            if (e8) model8 = ref_crc(model8, d8, 8);
            if (e2) model2 = ref_crc(model2, {6'b0, d2}, 2);
        end
        exp_q8.push_back(model8);
        exp_q2.push_back(model2);
        @(posedge clk);
        @(negedge clk);
        e8_v = exp_q8.pop_front();
        e2_v = exp_q2.pop_front();
        check_eq("crc8_step", crc8, e8_v);
        check_eq("crc2_step", crc2, e2_v);
        clr = 1'b0;
        en8 = 1'b0;
        en2 = 1'b0;
    endtask

    task automatic do_clear();
        tick(1'b0, 8'h00, 1'b0, 2'b00, 1'b1);
    endtask

    // One byte to both instances: dibits low first on dut2 every cycle,
    // the whole byte on dut8 on the first of the four cycles.
    task automatic feed_both(input logic [7:0] b);
        for (int k = 0; k < 4; k++) begin
            tick(k == 0, b, 1'b1, b[2*k +: 2], 1'b0);
        end
    endtask

    task automatic feed8(input logic [7:0] b);
        tick(1'b1, b, 1'b0, 2'b00, 1'b0);
    endtask

    // ---------------- stimulus ----------------
    logic [7:0]  frame [FRAME_LEN+4];
    logic [31:0] fcs_reg;
    logic [7:0]  bad_byte;

    initial begin
        model8 = INIT;
        model2 = INIT;

        // Reset only: value appears as soon as rst_n falls, then holds.
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_assert8", crc8, INIT);
        check_eq("rst_assert2", crc2, INIT);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) tick(1'b0, 8'h00, 1'b0, 2'b00, 1'b0);
        check_eq("rst_hold8", crc8, INIT);
        check_eq("rst_hold2", crc2, INIT);

        // Standard check vector "123456789" on both widths.
        for (int i = 0; i < 9; i++) feed_both(8'h31 + 8'(i));
        check_eq("chkvec8", crc8, CHECK_REG);
        check_eq("chkvec8_inv", ~crc8, 32'hCBF43926);
        check_eq("chkvec2", crc2, CHECK_REG);

        // Single 0x00 byte from init.
        do_clear();
        feed8(8'h00);
        check_eq("byte00", crc8, 32'h2DFD1072);

        // Frame plus its FCS must leave the residue on both widths.
        fcs_reg = INIT;
        for (int i = 0; i < FRAME_LEN; i++) begin
            frame[i] = 8'($urandom);
            fcs_reg  = ref_crc(fcs_reg, frame[i], 8);
        end
        fcs_reg = ~fcs_reg;
        for (int i = 0; i < 4; i++) frame[FRAME_LEN+i] = fcs_reg[8*i +: 8];
        do_clear();
        for (int i = 0; i < FRAME_LEN + 4; i++) feed_both(frame[i]);
        check_eq("residue8", crc8, RESIDUE);
        check_eq("residue2", crc2, RESIDUE);

        // One flipped bit anywhere must break the residue.
        for (int t = 0; t < 3; t++) begin
            int idx;
            int bit_n;
            idx   = $urandom_range(0, FRAME_LEN + 3);
            bit_n = $urandom_range(0, 7);
            do_clear();
            for (int i = 0; i < FRAME_LEN + 4; i++) begin
                bad_byte = frame[i];
                if (i == idx) bad_byte[bit_n] = ~bad_byte[bit_n];
                feed_both(bad_byte);
            end
            check_eq("corrupt8", {31'b0, crc8 != RESIDUE}, 32'd1);
            check_eq("corrupt2", {31'b0, crc2 != RESIDUE}, 32'd1);
        end

        // Gapped enable with random din while idle.
        do_clear();
        for (int i = 0; i < 9; i++) begin
            int gaps;
            gaps = $urandom_range(0, 3);
            for (int g = 0; g < gaps; g++) tick(1'b0, 8'h00, 1'b0, 2'b00, 1'b0);
            feed8(8'h31 + 8'(i));
        end
        check_eq("gapped8", crc8, CHECK_REG);

        // Clear together with enable mid-frame: clear wins.
        do_clear();
        for (int i = 0; i < 5; i++) feed_both(8'($urandom));
        tick(1'b1, 8'($urandom), 1'b1, 2'($urandom), 1'b1);
        check_eq("clr_en8", crc8, INIT);
        check_eq("clr_en2", crc2, INIT);

        // Reset mid-frame: init visible before any clock edge.
        for (int i = 0; i < 5; i++) feed_both(8'($urandom));
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_mid8", crc8, INIT);
        check_eq("rst_mid2", crc2, INIT);
        model8 = INIT;
        model2 = INIT;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 9; i++) feed_both(8'h31 + 8'(i));
        check_eq("post_rst8", crc8, CHECK_REG);
        check_eq("post_rst2", crc2, CHECK_REG);

        // ---------------- report ----------------
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
